// File: rtl/register_file_sb_if.sv
// Decode/writeback-facing bus of register_file_sb.
// The master modport is the pipeline side: it drives read and reservation
// requests and writebacks. The slave modport is the register file itself.
//   rd_/rs_regno_i, rd_/rs_data_o, rd_/rs_busy_o : two combinational read ports
//   rsv_i, rsv_regno_i, rsv_ack_o                 : pending-write reservation
//   wb_i, wb_regno_i, wb_data_i                   : writeback port
//   flush_i                                       : drop every pending count
//   pending_any_o, err_o                          : status (err_o is sticky)
interface register_file_sb_if #(
  parameter int LEN_REG   = 32,
  parameter int LEN_REGNO = 4
);
  logic [LEN_REGNO-1:0] rd_regno_i;
  logic [LEN_REGNO-1:0] rs_regno_i;
  logic [LEN_REG-1:0]   rd_data_o;
  logic [LEN_REG-1:0]   rs_data_o;
  logic                 rd_busy_o;
  logic                 rs_busy_o;
  logic                 rsv_i;
  logic [LEN_REGNO-1:0] rsv_regno_i;
  logic                 rsv_ack_o;
  logic                 wb_i;
  logic [LEN_REGNO-1:0] wb_regno_i;
  logic [LEN_REG-1:0]   wb_data_i;
  logic                 flush_i;
  logic                 pending_any_o;
  logic                 err_o;

  modport master (
    output rd_regno_i, rs_regno_i, rsv_i, rsv_regno_i,
           wb_i, wb_regno_i, wb_data_i, flush_i,
    input  rd_data_o, rs_data_o, rd_busy_o, rs_busy_o,
           rsv_ack_o, pending_any_o, err_o
  );

  modport slave (
    input  rd_regno_i, rs_regno_i, rsv_i, rsv_regno_i,
           wb_i, wb_regno_i, wb_data_i, flush_i,
    output rd_data_o, rs_data_o, rd_busy_o, rs_busy_o,
           rsv_ack_o, pending_any_o, err_o
  );
endinterface

// File: rtl/register_file_sb.sv
// General-register file with a per-register pending-write scoreboard.
// Each register keeps a saturating count of outstanding writes: decode
// reserves a register when it issues a writer, and writeback releases
// one reservation. Reads and busy flags are combinational, with an
// optional same-cycle writeback bypass.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (registers, counters, err_o)
//   bus  : register_file_sb_if slave modport (read ports, reservation,
//          writeback, flush, status)
module register_file_sb #(
  parameter int LEN_REG   = 32,
  parameter int LEN_REGNO = 4,
  parameter int LEN_PEND  = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 0
) (
  input  logic               clk,
  input  logic               rst,
  register_file_sb_if.slave  bus
);
  localparam int NREG = 2 ** LEN_REGNO;
  localparam logic [LEN_PEND-1:0] CNT_MAX = '1;
  localparam logic [LEN_PEND-1:0] CNT_ONE = LEN_PEND'(1);

  logic [LEN_REG-1:0]  r_regs [NREG];
  logic [LEN_PEND-1:0] r_cnt  [NREG];
  logic                r_err;

  logic [NREG-1:0] w_rsv_hit;
  logic [NREG-1:0] w_wb_hit;
  logic [NREG-1:0] w_nz;

  // A hard-wired r0 takes no part in counting or data storage.
  logic w_rsv_r0, w_wb_r0;
  logic w_rsv_cnt, w_wb_cnt, w_same;
  logic w_err_set;

  assign w_rsv_r0  = (ZERO_REG0 != 0) && (bus.rsv_regno_i == '0);
  assign w_wb_r0   = (ZERO_REG0 != 0) && (bus.wb_regno_i == '0);
  assign w_rsv_cnt = bus.rsv_i && !w_rsv_r0;
  assign w_wb_cnt  = bus.wb_i && !w_wb_r0;
  // Reserve and release of the same register cancel out.
  assign w_same    = w_rsv_cnt && w_wb_cnt && (bus.rsv_regno_i == bus.wb_regno_i);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign w_rsv_hit[gi] = w_rsv_cnt && (bus.rsv_regno_i == LEN_REGNO'(gi));
      assign w_wb_hit[gi]  = w_wb_cnt && (bus.wb_regno_i == LEN_REGNO'(gi));
      assign w_nz[gi]      = (r_cnt[gi] != '0);

      // Data is written on every valid writeback, flush or not.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_regs[gi] <= '0;
        end else if (w_wb_hit[gi]) begin
          r_regs[gi] <= bus.wb_data_i;
        end
      end

      // Counter saturates at CNT_MAX and floors at zero.
      always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
          r_cnt[gi] <= '0;
        end else if (w_rsv_hit[gi] && w_wb_hit[gi]) begin
          r_cnt[gi] <= r_cnt[gi];
        end else if (w_rsv_hit[gi] && (r_cnt[gi] != CNT_MAX)) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
        end else if (w_wb_hit[gi] && (r_cnt[gi] != '0)) begin
          r_cnt[gi] <= r_cnt[gi] - CNT_ONE;
        end
      end
    end
  endgenerate

  // Writeback with nothing outstanding is a pipeline bookkeeping error.
  // A flush discards the count, so no error is raised during it.
  assign w_err_set = w_wb_cnt && !bus.flush_i && !w_same &&
                     (r_cnt[bus.wb_regno_i] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // During flush the request is acknowledged so decode proceeds,
  // but the reservation itself is dropped.
  assign bus.rsv_ack_o = bus.rsv_i &&
                         (bus.flush_i || w_rsv_r0 || w_same ||
                          (r_cnt[bus.rsv_regno_i] != CNT_MAX));

  // Read port A
  logic w_rd_byp, w_rd_rsv;
  assign w_rd_byp = (BYPASS != 0) && w_wb_cnt && (bus.wb_regno_i == bus.rd_regno_i);
  assign w_rd_rsv = w_rsv_cnt && (bus.rsv_regno_i == bus.rd_regno_i);
  assign bus.rd_data_o = ((ZERO_REG0 != 0) && (bus.rd_regno_i == '0)) ? '0 :
                         w_rd_byp ? bus.wb_data_i : r_regs[bus.rd_regno_i];
  // The last outstanding write retiring this cycle frees the register now.
  assign bus.rd_busy_o = w_nz[bus.rd_regno_i] &&
                         !(w_rd_byp && (r_cnt[bus.rd_regno_i] == CNT_ONE) && !w_rd_rsv);

  // Read port B
  logic w_rs_byp, w_rs_rsv;
  assign w_rs_byp = (BYPASS != 0) && w_wb_cnt && (bus.wb_regno_i == bus.rs_regno_i);
  assign w_rs_rsv = w_rsv_cnt && (bus.rsv_regno_i == bus.rs_regno_i);
  assign bus.rs_data_o = ((ZERO_REG0 != 0) && (bus.rs_regno_i == '0)) ? '0 :
                         w_rs_byp ? bus.wb_data_i : r_regs[bus.rs_regno_i];
  assign bus.rs_busy_o = w_nz[bus.rs_regno_i] &&
                         !(w_rs_byp && (r_cnt[bus.rs_regno_i] == CNT_ONE) && !w_rs_rsv);

  assign bus.pending_any_o = |w_nz;
  assign bus.err_o         = r_err;
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb. dut_a uses BYPASS=1, ZERO_REG0=0;
// dut_b shares the same stimulus with BYPASS=0, ZERO_REG0=1.
module tb_register_file_sb;
  localparam int LR = 32;
  localparam int LN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_sb_if #(.LEN_REG(LR), .LEN_REGNO(LN)) bus_a ();
  register_file_sb_if #(.LEN_REG(LR), .LEN_REGNO(LN)) bus_b ();

  register_file_sb #(.LEN_REG(LR), .LEN_REGNO(LN), .LEN_PEND(2), .BYPASS(1), .ZERO_REG0(0))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  register_file_sb #(.LEN_REG(LR), .LEN_REGNO(LN), .LEN_PEND(2), .BYPASS(0), .ZERO_REG0(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  assign bus_b.rd_regno_i  = bus_a.rd_regno_i;
  assign bus_b.rs_regno_i  = bus_a.rs_regno_i;
  assign bus_b.rsv_i       = bus_a.rsv_i;
  assign bus_b.rsv_regno_i = bus_a.rsv_regno_i;
  assign bus_b.wb_i        = bus_a.wb_i;
  assign bus_b.wb_regno_i  = bus_a.wb_regno_i;
  assign bus_b.wb_data_i   = bus_a.wb_data_i;
  assign bus_b.flush_i     = bus_a.flush_i;

  typedef struct {
    logic        rst;
    logic        rsv;
    logic [3:0]  rsv_regno;
    logic        wb;
    logic [3:0]  wb_regno;
    logic [31:0] wb_data;
    logic        flush;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_rs_busy;
    logic        e_ack;
    logic        e_pend;
    logic        e_err;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  int n_vec  = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic r, logic rsv, logic [3:0] rn, logic wb, logic [3:0] wn,
                              logic [31:0] wd, logic fl, logic [3:0] rd, logic [3:0] rs,
                              logic [31:0] ed, logic eb, logic erb, logic ea, logic ep, logic ee);
    vec_t v;
    v.rst = r; v.rsv = rsv; v.rsv_regno = rn; v.wb = wb; v.wb_regno = wn;
    v.wb_data = wd; v.flush = fl; v.rd = rd; v.rs = rs;
    v.e_data = ed; v.e_busy = eb; v.e_rs_busy = erb; v.e_ack = ea; v.e_pend = ep; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the edge; return at the falling edge
  // so combinational outputs and registered state are stable for checking.
  task automatic step(input logic r, input logic rsv, input logic [3:0] rn, input logic wb,
                      input logic [3:0] wn, input logic [31:0] wd, input logic fl,
                      input logic [3:0] rd, input logic [3:0] rs);
    @(posedge clk);
    #1;
    rst = r;
    bus_a.rsv_i = rsv; bus_a.rsv_regno_i = rn;
    bus_a.wb_i = wb; bus_a.wb_regno_i = wn; bus_a.wb_data_i = wd;
    bus_a.flush_i = fl; bus_a.rd_regno_i = rd; bus_a.rs_regno_i = rs;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.rsv_i = 1'b0; bus_a.rsv_regno_i = '0;
    bus_a.wb_i = 1'b0; bus_a.wb_regno_i = '0; bus_a.wb_data_i = '0;
    bus_a.flush_i = 1'b0; bus_a.rd_regno_i = '0; bus_a.rs_regno_i = '0;

    //             rst rsv rn wb wn  data          fl rd rs   data          bsy rsb ack pnd err
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 3, 0, 32'h0,        0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,        0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 32'h0,        0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 5, 0, 0, 32'h0,        0, 5, 0, 32'h0,        0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 1, 5, 0, 0, 32'h0,        0, 5, 0, 32'h0,        1, 0, 1, 1, 0);
    vecs[6]  = mk(0, 1, 5, 0, 0, 32'h0,        0, 5, 0, 32'h0,        1, 0, 1, 1, 0);
    vecs[7]  = mk(0, 1, 5, 0, 0, 32'h0,        0, 5, 0, 32'h0,        1, 0, 0, 1, 0);
    vecs[8]  = mk(0, 1, 5, 1, 5, 32'hA5,       0, 5, 0, 32'hA5,       1, 0, 1, 1, 0);
    vecs[9]  = mk(0, 1, 5, 0, 0, 32'h0,        0, 5, 0, 32'hA5,       1, 0, 0, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 5, 32'h1,        0, 5, 0, 32'h1,        1, 0, 0, 1, 0);
    vecs[11] = mk(0, 0, 0, 1, 5, 32'h2,        0, 5, 0, 32'h2,        1, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 5, 32'h3,        0, 5, 0, 32'h3,        0, 0, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 32'h0,        0, 5, 0, 32'h3,        0, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 0, 0, 32'h0,        0, 1, 2, 32'h0,        0, 0, 1, 0, 0);
    vecs[15] = mk(0, 1, 2, 0, 0, 32'h0,        0, 1, 2, 32'h0,        1, 0, 1, 1, 0);
    vecs[16] = mk(0, 1, 2, 1, 1, 32'h55,       1, 1, 2, 32'h55,       0, 1, 1, 1, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,        0, 1, 2, 32'h55,       0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 1, 7, 32'h12,       0, 7, 0, 32'h12,       0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 32'h0,        0, 7, 0, 32'h12,       0, 0, 0, 0, 1);
    vecs[20] = mk(0, 1, 7, 0, 0, 32'h0,        0, 7, 0, 32'h12,       0, 0, 1, 0, 1);
    vecs[21] = mk(0, 0, 0, 1, 7, 32'h34,       0, 7, 0, 32'h34,       0, 0, 0, 1, 1);
    vecs[22] = mk(1, 0, 0, 0, 0, 32'h0,        0, 7, 0, 32'h34,       0, 0, 0, 0, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 32'h0,        0, 7, 0, 32'h0,        0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].rsv, vecs[i].rsv_regno, vecs[i].wb, vecs[i].wb_regno,
           vecs[i].wb_data, vecs[i].flush, vecs[i].rd, vecs[i].rs);
      n_vec++;
      chk($sformatf("v%0d rd_data", i), bus_a.rd_data_o, vecs[i].e_data);
      chk($sformatf("v%0d rd_busy", i), 32'(bus_a.rd_busy_o), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d rs_busy", i), 32'(bus_a.rs_busy_o), 32'(vecs[i].e_rs_busy));
      chk($sformatf("v%0d rsv_ack", i), 32'(bus_a.rsv_ack_o), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d pending_any", i), 32'(bus_a.pending_any_o), 32'(vecs[i].e_pend));
      chk($sformatf("v%0d err", i), 32'(bus_a.err_o), 32'(vecs[i].e_err));
      $display("vec %0d: rd=%0d data=%h busy=%b ack=%b pend=%b err=%b", i, vecs[i].rd,
               bus_a.rd_data_o, bus_a.rd_busy_o, bus_a.rsv_ack_o, bus_a.pending_any_o, bus_a.err_o);
    end

    // Hard-wired r0 (dut_b), contrasted with an ordinary r0 (dut_a).
    step(0, 0, 0, 1, 0, 32'hFF, 0, 0, 0);
    n_vec++;
    chk("r0 wb b rd_data", bus_b.rd_data_o, 32'h0);
    chk("r0 wb a bypass", bus_a.rd_data_o, 32'hFF);
    $display("seq r0 wb: a=%h b=%h", bus_a.rd_data_o, bus_b.rd_data_o);

    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    n_vec++;
    chk("r0 read b", bus_b.rd_data_o, 32'h0);
    chk("r0 err b", 32'(bus_b.err_o), 32'h0);
    chk("r0 read a", bus_a.rd_data_o, 32'hFF);
    chk("r0 err a", 32'(bus_a.err_o), 32'h1);
    $display("seq r0 read: a=%h b=%h err a=%b b=%b", bus_a.rd_data_o, bus_b.rd_data_o,
             bus_a.err_o, bus_b.err_o);

    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 0, 32'h0, 0, 0, 0);
      n_vec++;
      chk($sformatf("r0 rsv%0d b ack", k), 32'(bus_b.rsv_ack_o), 32'h1);
      chk($sformatf("r0 rsv%0d b busy", k), 32'(bus_b.rd_busy_o), 32'h0);
      chk($sformatf("r0 rsv%0d b pend", k), 32'(bus_b.pending_any_o), 32'h0);
      chk($sformatf("r0 rsv%0d a ack", k), 32'(bus_a.rsv_ack_o), (k < 3) ? 32'h1 : 32'h0);
      $display("seq r0 rsv %0d: ack a=%b b=%b", k, bus_a.rsv_ack_o, bus_b.rsv_ack_o);
    end

    // Without bypass the written value appears one cycle later.
    step(0, 0, 0, 1, 3, 32'hDEADBEEF, 0, 3, 3);
    n_vec++;
    chk("nobyp same-cycle", bus_b.rd_data_o, 32'h0);
    $display("seq nobyp wb r3: b rd=%h", bus_b.rd_data_o);

    step(0, 0, 0, 0, 0, 32'h0, 0, 3, 3);
    n_vec++;
    chk("nobyp next rd", bus_b.rd_data_o, 32'hDEADBEEF);
    chk("nobyp next rs", bus_b.rs_data_o, 32'hDEADBEEF);
    chk("nobyp err b", 32'(bus_b.err_o), 32'h1);
    $display("seq nobyp next: b rd=%h rs=%h err=%b", bus_b.rd_data_o, bus_b.rs_data_o,
             bus_b.err_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised general-register file with a per-register pending-write scoreboard, successor to the single-reservation register block.
- Sits between decode (read ports, reservations) and writeback (write port).
- Each register counts several outstanding writes, with optional same-cycle write-to-read bypass, pipeline flush and an underflow error flag.
- Decode stalls on busy_o outputs and on rsv_ack_o deassertion.

Parameters:
LEN_REG, 32, data width of each register
LEN_REGNO, 4, register-number width; register count = 2**LEN_REGNO
LEN_PEND, 2, pending-write counter width; max outstanding writes per register = 2**LEN_PEND-1
BYPASS, 1, 1 = read ports return wb_data_i when a same-cycle writeback targets the read register
ZERO_REG0, 0, 1 = register 0 is hard-wired zero and never reserved

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
rd_regno_i  input  LEN_REGNO  read port A register number
rs_regno_i  input  LEN_REGNO  read port B register number
rd_data_o  output  LEN_REG  read port A data (combinational)
rs_data_o  output  LEN_REG  read port B data (combinational)
rd_busy_o  output  1  port A register has pending writes
rs_busy_o  output  1  port B register has pending writes
rsv_i  input  1  reserve request (issue of an instruction writing rsv_regno_i)
rsv_regno_i  input  LEN_REGNO  register to reserve
rsv_ack_o  output  1  reservation accepted this cycle (combinational)
wb_i  input  1  writeback valid
wb_regno_i  input  LEN_REGNO  writeback register number
wb_data_i  input  LEN_REG  writeback data
flush_i  input  1  clear all pending counters
pending_any_o  output  1  at least one counter nonzero (registered state, combinational OR)
err_o  output  1  sticky: writeback to a register with zero pending count

Behaviour:
Reset (rst=1 at clk edge):
- All registers, all counters and err_o go to 0.
- pending_any_o and busy outputs read 0 the cycle after reset.

Write port:
- When wb_i=1, reg[wb_regno_i] <= wb_data_i at the edge, regardless of flush_i or counter state.

Read ports:
- Combinational: data = reg[regno].
- If BYPASS=1 and wb_i=1 and wb_regno_i==regno, data = wb_data_i.
- With BYPASS=0, written data is visible the cycle after the edge.

Counters, cnt[r], per edge in priority order:
- rst: clear all counters.
- flush_i: all cnt <= 0; rsv_i/wb_i ignored for counting (wb data still written).
- rsv_i and wb_i on the same register: cnt unchanged; ack=1 even if saturated.
- rsv_i alone on that register: if cnt < max, cnt+1 and ack=1; if saturated, ack=0 and cnt unchanged.
- wb_i: if cnt>0, cnt-1; if cnt==0, cnt stays 0 and err_o <= 1.
- rsv_i and wb_i on different registers update independently.

rsv_ack_o:
- Combinational; equals 0 when rsv_i=0.
- During flush_i=1, rsv_ack_o=1 but the reservation is discarded.

busy:
- busy = (cnt[regno]!=0).
- With BYPASS=1, busy is also forced 0 when wb_i hits that register with cnt==1 and no same-cycle rsv_i to it.

ZERO_REG0=1:
- Reads of r0 return 0; writes to r0 are dropped.
- rsv to r0 always ack=1 and never counts; wb to r0 never sets err_o; busy for r0 is 0.

Latency and width:
- Read and busy have zero latency; counters and data update at the clock edge.
- Counters wrap never: saturate at max and floor at 0.
- err_o is cleared only by rst.

Test Plan:
1. Reset, then read r0..r15 -> all data 0, busy 0, pending_any_o 0, err_o 0.
2. Writeback r3=0xDEADBEEF, and read r3 in the same cycle: BYPASS=1 -> rd_data_o=0xDEADBEEF that cycle; BYPASS=0 -> old value, then 0xDEADBEEF the next cycle.
3. LEN_PEND=2, rsv r5 on four consecutive cycles -> ack 1,1,1,0; rd_busy_o=1; then three wb r5 -> busy clears in the cycle of the third wb (BYPASS=1), err_o stays 0.
4. r5 saturated (cnt=3), rsv r5 and wb r5 in the same cycle -> ack=1, cnt stays 3; rsv r5 alone the next cycle -> ack=0.
5. wb r7 with cnt=0, data 0x12 -> r7 reads 0x12, err_o=1, and err_o stays 1 until rst.
6. Reserve r1 and r2, then flush_i with a simultaneous wb r1=0x55 -> all counters 0, pending_any_o=0 the next cycle, r1 reads 0x55, err_o=0. With ZERO_REG0=1, wb r0=0xFF -> r0 reads 0.
